// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D-cache memory arbiter: default widths,
// FSM state encoding and the last-grant owner encoding used by round-robin.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the two caches, the arbiter and the shared memory port.
// The arbiter connects through the slave modport; caches/memory use master.
interface mem_arb_if
#(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);

    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ready;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_mem_read, i_mem_addr,
        output i_mem_rdata, i_mem_ready,
        input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        output d_mem_rdata, d_mem_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output i_mem_read, i_mem_addr,
        input  i_mem_rdata, i_mem_ready,
        output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        input  d_mem_rdata, d_mem_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the I-cache and D-cache requests.
// On a tie the requester that did not win last time is chosen.
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic last_was_d,
    output logic grant_i,
    output logic grant_d
);

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            if (last_was_d) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else if (d_req) begin
            grant_d = 1'b1;
        end else if (i_req) begin
            grant_i = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared line-memory port between I-cache and D-cache.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed D-over-I priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_arb_if.slave bus
);

    arb_state_e        state_q;
    arb_state_e        state_d;

    logic              i_req;
    logic              d_req;
    logic              pick_i;
    logic              pick_d;
    logic              last_was_d;

    logic              rd_sel;
    logic              wr_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              i_ready;
    logic              d_ready;

    // A simultaneous read+write from the D-cache counts as one write request.
    assign i_req = bus.i_mem_read;
    assign d_req = bus.d_mem_read | bus.d_mem_write;

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_was_d (last_was_d),
        .grant_i    (pick_i),
        .grant_d    (pick_d)
    );

`ifdef MEM_ARB_RR_EN
    owner_e last_grant_q;
    owner_e last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE) begin
            if (pick_d) begin
                last_grant_d = OWNER_D;
            end else if (pick_i) begin
                last_grant_d = OWNER_I;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= OWNER_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_was_d = (last_grant_q == OWNER_D);
`else
    assign last_was_d = 1'b0;
`endif

    // Grants end on mem_ready or when the owner withdraws its request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = GNT_D;
                end else if (pick_i) begin
                    state_d = GNT_I;
                end
            end
            GNT_I: begin
                if (bus.mem_ready || !i_req) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (bus.mem_ready || !d_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        rd_sel    = 1'b0;
        wr_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        i_ready   = 1'b0;
        d_ready   = 1'b0;
        case (state_q)
            GNT_I: begin
                rd_sel   = bus.i_mem_read;
                addr_sel = bus.i_mem_addr;
                i_ready  = bus.mem_ready;
            end
            GNT_D: begin
                wr_sel    = bus.d_mem_write;
                rd_sel    = bus.d_mem_read & ~bus.d_mem_write;
                addr_sel  = bus.d_mem_addr;
                wdata_sel = bus.d_mem_wdata;
                d_ready   = bus.mem_ready;
            end
            default: ;
        endcase
    end

    assign bus.mem_read    = rd_sel;
    assign bus.mem_write   = wr_sel;
    assign bus.mem_addr    = addr_sel;
    assign bus.mem_wdata   = wdata_sel;
    assign bus.i_mem_ready = i_ready;
    assign bus.d_mem_ready = d_ready;
    assign bus.i_mem_rdata = i_ready ? bus.mem_rdata : '0;
    assign bus.d_mem_rdata = d_ready ? bus.mem_rdata : '0;

endmodule
